// File: rtl/btn_evt_pkg.sv
// Shared event-type encoding and channel-count bound for the button event arbiter.
package btn_evt_pkg;

    localparam int unsigned N_BTN_MAX = 16;

    typedef enum logic {
        EVT_UP   = 1'b0,
        EVT_DOWN = 1'b1
    } evt_type_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    int unsigned idx;
    logic [IW-1:0] sel;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            sel = IW'(idx);
            if (!gnt_any && req[sel]) begin
                gnt_any  = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Serialises per-channel press/release pulses into one valid/ready event stream,
// round-robin across channels, preserving per-channel order and flagging overruns.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN = 4,
    parameter int unsigned CW    = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_up,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CW-1:0]    evt_chan,
    output logic             evt_type,
    output logic [N_BTN-1:0] overrun,
    input  logic             clr_overrun
);

    logic [N_BTN-1:0] pend_dn, pend_up, older;
    logic [N_BTN-1:0] pend_dn_d, pend_up_d, older_d, overrun_d;
    logic [N_BTN-1:0] offer_type, gnt, clr_dn, clr_up, dn_rem, up_rem, ovr_set;
    logic [CW-1:0]    ptr, ptr_nxt, gnt_idx;
    logic             gnt_any, load;
    evt_type_e        evt_type_q;

    assign load     = ~evt_valid | evt_ready;
    assign evt_type = evt_type_q;

    rr_arbiter #(
        .WIDTH (N_BTN),
        .IW    (CW)
    ) u_rr_arbiter (
        .req     (pend_dn | pend_up),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // With both types pending a channel offers the older one; otherwise whichever is set.
    assign offer_type = (pend_dn & pend_up & older) | (pend_dn & ~pend_up);

    assign clr_dn    = {N_BTN{load}} & gnt & offer_type;
    assign clr_up    = {N_BTN{load}} & gnt & ~offer_type;
    assign dn_rem    = pend_dn & ~clr_dn;
    assign up_rem    = pend_up & ~clr_up;
    assign pend_dn_d = dn_rem | btn_down;
    assign pend_up_d = up_rem | btn_up;
    assign ovr_set   = (btn_down & dn_rem) | (btn_up & up_rem);
    assign overrun_d = (clr_overrun ? '0 : overrun) | ovr_set;
    assign ptr_nxt   = (gnt_idx == CW'(N_BTN - 1)) ? '0 : gnt_idx + CW'(1);

    always_comb begin
        older_d = older;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_up[i] && dn_rem[i] && !up_rem[i]) begin
                older_d[i] = EVT_DOWN;
            end else if (btn_down[i] && up_rem[i] && !dn_rem[i]) begin
                older_d[i] = EVT_UP;
            end else if (btn_down[i] && btn_up[i] && !dn_rem[i] && !up_rem[i]) begin
                older_d[i] = EVT_DOWN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dn    <= '0;
            pend_up    <= '0;
            older      <= '0;
            overrun    <= '0;
            ptr        <= '0;
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_type_q <= EVT_UP;
        end else begin
            pend_dn <= pend_dn_d;
            pend_up <= pend_up_d;
            older   <= older_d;
            overrun <= overrun_d;
            if (load) begin
                if (gnt_any) begin
                    evt_valid  <= 1'b1;
                    evt_chan   <= gnt_idx;
                    evt_type_q <= evt_type_e'(offer_type[gnt_idx]);
                    ptr        <= ptr_nxt;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected events, a negedge monitor checks handshakes.
module tb_button_event_arbiter;
    import btn_evt_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  btn_down, btn_up, overrun;
    logic          evt_valid, evt_ready, evt_type, clr_overrun;
    logic [CW-1:0] evt_chan;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic          typ;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_down    (btn_down),
        .btn_up      (btn_up),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_type    (evt_type),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [N-1:0] dn, input logic [N-1:0] up, input logic clr = 1'b0);
        btn_down    = dn;
        btn_up      = up;
        clr_overrun = clr;
        step();
        btn_down    = '0;
        btn_up      = '0;
        clr_overrun = 1'b0;
    endtask

    task automatic expect_evt(input int unsigned c, input logic t);
        evt_t e;
        e.chan = CW'(c);
        e.typ  = t;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got chan=%0d type=%0d expected none",
                         evt_chan, evt_type);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_chan", evt_chan, mon_e.chan);
                check("evt_type", evt_type, mon_e.typ);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        btn_down    = '0;
        btn_up      = '0;
        clr_overrun = 1'b0;
        evt_ready   = 1'b1;
        step(3);
        check("reset_valid", evt_valid, 0);
        check("reset_chan", evt_chan, 0);
        check("reset_type", evt_type, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // Single press on ch2, two-cycle latency
        expect_evt(2, EVT_DOWN);
        btn_down = 4'b0100;
        step();
        btn_down = '0;
        check("latency_edge_e", evt_valid, 0);
        step();
        check("latency_edge_e1", evt_valid, 1);
        check("latency_chan", evt_chan, 2);
        step(4);
        check("single_idle", evt_valid, 0);

        // ch0+ch2 together, then ch0 again (collides with its grant) plus ch1
        expect_evt(0, EVT_DOWN);
        expect_evt(1, EVT_DOWN);
        expect_evt(2, EVT_DOWN);
        expect_evt(0, EVT_DOWN);
        btn_down = 4'b0101;
        step();
        btn_down = 4'b0011;
        step();
        btn_down = '0;
        step(5);
        check("collision_overrun", overrun, 0);

        // Stall ordering: ch1 down then up; ch2 up then down
        evt_ready = 1'b0;
        expect_evt(1, EVT_DOWN);
        expect_evt(2, EVT_UP);
        expect_evt(1, EVT_UP);
        expect_evt(2, EVT_DOWN);
        pulse(4'b0010, 4'b0000);
        step(4);
        pulse(4'b0000, 4'b0010);
        pulse(4'b0000, 4'b0100);
        pulse(4'b0100, 4'b0000);
        step();
        check("stall_valid", evt_valid, 1);
        check("stall_chan", evt_chan, 1);
        check("stall_type", evt_type, EVT_DOWN);
        check("stall_overrun", overrun, 0);
        evt_ready = 1'b1;
        step(6);

        // Overrun on ch3 while output is occupied by ch0
        evt_ready = 1'b0;
        expect_evt(0, EVT_DOWN);
        expect_evt(3, EVT_DOWN);
        pulse(4'b0001, 4'b0000);
        pulse(4'b1000, 4'b0000);
        pulse(4'b1000, 4'b0000);
        check("overrun_set", overrun, 4'b1000);
        pulse(4'b0000, 4'b0000, 1'b1);
        check("overrun_clr", overrun, 0);
        evt_ready = 1'b1;
        step(4);
        evt_ready = 1'b0;

        // Clear coincident with a new overrun: set wins
        expect_evt(1, EVT_DOWN);
        expect_evt(3, EVT_DOWN);
        pulse(4'b0010, 4'b0000);
        pulse(4'b1000, 4'b0000);
        pulse(4'b1000, 4'b0000, 1'b1);
        check("overrun_set_wins", overrun, 4'b1000);
        pulse(4'b0000, 4'b0000, 1'b1);
        evt_ready = 1'b1;
        step(4);

        // Asynchronous reset with events queued
        evt_ready = 1'b0;
        pulse(4'b0111, 4'b0000);
        step();
        check("pre_reset_valid", evt_valid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", evt_valid, 0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        evt_ready = 1'b1;
        step(5);
        check("post_reset_idle", evt_valid, 0);

        // ptr restarted at 0: ch0 must beat ch3
        expect_evt(0, EVT_DOWN);
        expect_evt(3, EVT_DOWN);
        pulse(4'b1001, 4'b0000);
        step(5);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
